wb_mem_stage: RTL

- Write-back/memory stage; consumes the EX/WB pipeline register outputs (`*_wb` signals).
- Performs data-RAM reads and writes over a req/ack handshake.
- Selects the write-back value and drives the register-file write port.
- Stalls upstream stages while a RAM access is outstanding, and aborts hung accesses via a timeout with a sticky error flag.

---
 rtl/wb_mem_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/wb_mem_stage.sv
// Write-back / memory stage: issues data-RAM accesses over a req/ack handshake,
// stalls upstream while one is outstanding, and drives the register-file write port.
module wb_mem_stage #(
  parameter int pc_width    = 10,
  parameter int index_width = 3,
  parameter int reg_width   = 32,
  parameter int addr_width  = 10,
  parameter int data_width  = 32,
  parameter int timeout     = 255,
  parameter int to_width    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [pc_width-1:0]    pc_next_wb,
  input  logic                   memRead_wb,
  input  logic                   memWrite_wb,
  input  logic                   aluToReg_wb,
  input  logic                   constToReg_wb,
  input  logic                   regWrite_wb,
  input  logic [index_width-1:0] op0_wb,
  input  logic [reg_width-1:0]   resAlu_wb,
  input  logic [addr_width-1:0]  addrRam_wb,
  input  logic [data_width-1:0]  wr_dataRam_wb,
  output logic                   ram_req,
  output logic                   ram_we,
  output logic [addr_width-1:0]  ram_addr,
  output logic [data_width-1:0]  ram_wdata,
  input  logic [data_width-1:0]  ram_rdata,
  input  logic                   ram_ack,
  output logic                   stall,
  output logic                   rf_we,
  output logic [index_width-1:0] rf_idx,
  output logic [reg_width-1:0]   rf_wdata,
  output logic                   bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [to_width-1:0] c_to_last = to_width'(timeout - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_ram_req;
  logic                  r_ram_we;
  logic [addr_width-1:0] r_ram_addr;
  logic [data_width-1:0] r_ram_wdata;
  logic [data_width-1:0] r_rdata;
  logic [to_width-1:0]   r_timer;
  logic                  r_bus_err;

  logic                  w_mem_op;
  logic                  w_expire;
  logic [reg_width-1:0]  w_mux_data;

  assign w_mem_op = memRead_wb | memWrite_wb;
  assign w_expire = (timeout != 0) && (r_timer == c_to_last);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_mem_op) w_state_next = S_BUSY;
      S_BUSY:  if (ram_ack || w_expire) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_req   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rdata     <= '0;
      r_timer     <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            r_ram_req   <= 1'b1;
            r_ram_addr  <= addrRam_wb;
            r_ram_wdata <= wr_dataRam_wb;
            // A combined read+write request is treated as a read.
            r_ram_we    <= memWrite_wb & ~memRead_wb;
            r_timer     <= '0;
          end
        end
        S_BUSY: begin
          if (ram_ack) begin
            r_ram_req <= 1'b0;
            if (!r_ram_we) r_rdata <= ram_rdata;
          end else if (w_expire) begin
            r_ram_req <= 1'b0;
            r_rdata   <= '0;
            r_bus_err <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_mux_data = '0;
    if (aluToReg_wb)        w_mux_data = resAlu_wb;
    else if (constToReg_wb) w_mux_data = reg_width'(pc_next_wb);
  end

  always_comb begin
    stall    = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = w_mux_data;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          stall = w_mem_op;
          rf_we = regWrite_wb & ~w_mem_op;
        end
        S_BUSY: stall = 1'b1;
        S_DONE: begin
          rf_we = regWrite_wb;
          if (memRead_wb) rf_wdata = r_rdata;
        end
        default: ;
      endcase
    end
  end

  assign ram_req   = r_ram_req;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign rf_idx    = op0_wb;
  assign bus_err   = r_bus_err;

endmodule
